// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits MSB first, optional parity, STOP_BITS stop bits.
// A one-word holding register lets consecutive frames go out with no idle gap.
module uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              sck,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              TX,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = 4;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              wrap, accept, load;
    logic [DATA_W-1:0] load_word;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        full_d    = full_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        par_d     = par_q;
        load      = 1'b0;
        load_word = hold_q;
        wrap      = (baud_q == BAUD_LAST);
        accept    = valid_in && !full_q;
        baud_d    = (state_q == IDLE || wrap) ? '0 : baud_q + CNT_W'(1);

        if (accept) begin
            hold_d = data_in;
            full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (full_q) load = 1'b1;
            end
            START: if (wrap) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[DATA_W-1];
                shift_d = shift_q << 1;
            end
            DATA: if (wrap) begin
                if (bit_q == DATA_LAST) begin
                    bit_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + BIT_W'(1);
                    tx_d    = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                end
            end
            PARITY: if (wrap) begin
                state_d = STOP;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
            STOP: if (wrap) begin
                if (bit_q == STOP_LAST) begin
                    // A word arriving on the final stop edge goes straight to the shifter.
                    if (full_q) begin
                        load = 1'b1;
                    end else if (accept) begin
                        load      = 1'b1;
                        load_word = data_in;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d = load_word;
            par_d   = (^load_word) ^ (PARITY_ODD != 0);
            full_d  = 1'b0;
            state_d = START;
            tx_d    = 1'b0;
            bit_d   = '0;
            baud_d  = '0;
        end

        done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            full_q  <= full_d;
            done_q  <= done_d;
        end
    end

    // Data-path registers carry no reset; full_q/state_q qualify their contents.
    always_ff @(posedge sck) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign TX        = tx_q;
    assign ready_out = !full_q;
    assign busy      = (state_q != IDLE) || full_q;
    assign tx_done   = done_q;

endmodule
